// File: rtl/srv_icb_mem_pipe.sv
// ICB slave to single-port SRAM bridge: RD_LAT-deep read pipe, credit-limited outstanding
// commands, fall-through response FIFO. Define SRV_ICB_MEM_ADDR_CHK_EN to flag out-of-range
// addresses as errors.
module srv_icb_mem_pipe #(
   parameter int unsigned AW_ICB    = 32,
   parameter int unsigned AW_MEM    = 10,
   parameter int unsigned DW        = 32,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned OST_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              icb_cmd_valid,
   output logic              icb_cmd_ready,
   input  logic [AW_ICB-1:0] icb_cmd_addr,
   input  logic              icb_cmd_read,
   input  logic [DW-1:0]     icb_cmd_wdata,
   input  logic [DW/8-1:0]   icb_cmd_wmask,
   output logic              icb_resp_valid,
   input  logic              icb_resp_ready,
   output logic [DW-1:0]     icb_resp_rdata,
   output logic              icb_resp_err,
   output logic              mem_ce,
   output logic              mem_we,
   output logic [AW_MEM-1:0] mem_addr,
   output logic [DW-1:0]     mem_bwe,
   output logic [DW-1:0]     mem_din,
   input  logic [DW-1:0]     mem_dout
);

   localparam int unsigned ADDR_S = $clog2(DW / 8);
   localparam int unsigned PW     = $clog2(OST_DEPTH);
   localparam int unsigned CW     = PW + 1;
   localparam logic [PW:0] ONE    = {{PW{1'b0}}, 1'b1};

   logic cmd_hsk;
   logic resp_hsk;
   logic addr_err;
   logic unused_addr;

   // ---------------------------------------------------------------------------------------
   // Address check and SRAM drive
   // ---------------------------------------------------------------------------------------
`ifdef SRV_ICB_MEM_ADDR_CHK_EN
   assign addr_err = |icb_cmd_addr[AW_ICB-1:AW_MEM+ADDR_S];
`else
   assign addr_err = 1'b0;
`endif
   // Byte-offset bits (and upper bits when unchecked) never reach the SRAM.
   assign unused_addr = ^icb_cmd_addr;

   assign cmd_hsk  = icb_cmd_valid & icb_cmd_ready;
   assign resp_hsk = icb_resp_valid & icb_resp_ready;

   assign mem_ce   = cmd_hsk & ~addr_err;
   assign mem_we   = ~icb_cmd_read;
   assign mem_addr = icb_cmd_addr[ADDR_S +: AW_MEM];
   assign mem_din  = icb_cmd_wdata;

   always_comb begin
      mem_bwe = '0;
      for (int i = 0; i < int'(DW / 8); i++) begin
         mem_bwe[8*i +: 8] = {8{icb_cmd_wmask[i]}};
      end
   end

   // ---------------------------------------------------------------------------------------
   // Credit counter
   // ---------------------------------------------------------------------------------------
   logic [CW-1:0] ost_cnt_q, ost_cnt_d;

   // A full counter still accepts when a response retires in the same cycle.
   assign icb_cmd_ready = (ost_cnt_q < CW'(OST_DEPTH)) | resp_hsk;

   always_comb begin
      ost_cnt_d = ost_cnt_q;
      if (cmd_hsk && !resp_hsk) begin
         ost_cnt_d = ost_cnt_q + ONE;
      end else if (!cmd_hsk && resp_hsk) begin
         ost_cnt_d = ost_cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ost_cnt_q <= '0;
      end else begin
         ost_cnt_q <= ost_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Response pipeline, aligned with the SRAM read latency
   // ---------------------------------------------------------------------------------------
   logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0] pipe_rd_q, pipe_rd_d;
   logic [RD_LAT-1:0] pipe_err_q, pipe_err_d;

   always_comb begin
      pipe_vld_d    = pipe_vld_q;
      pipe_rd_d     = pipe_rd_q;
      pipe_err_d    = pipe_err_q;
      // Every accepted command enters, even errored ones, so order is preserved.
      pipe_vld_d[0] = cmd_hsk;
      pipe_rd_d[0]  = icb_cmd_read;
      pipe_err_d[0] = addr_err;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_rd_d[i]  = pipe_rd_q[i-1];
         pipe_err_d[i] = pipe_err_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld_q <= '0;
         pipe_rd_q  <= '0;
         pipe_err_q <= '0;
      end else begin
         pipe_vld_q <= pipe_vld_d;
         pipe_rd_q  <= pipe_rd_d;
         pipe_err_q <= pipe_err_d;
      end
   end

   logic          arr_vld;
   logic          arr_err;
   logic [DW-1:0] arr_data;

   assign arr_vld  = pipe_vld_q[RD_LAT-1];
   assign arr_err  = arr_vld & pipe_err_q[RD_LAT-1];
   assign arr_data = (arr_vld && pipe_rd_q[RD_LAT-1] && !pipe_err_q[RD_LAT-1]) ? mem_dout : '0;

   // ---------------------------------------------------------------------------------------
   // Response FIFO, first-word fall-through with arrival bypass
   // ---------------------------------------------------------------------------------------
   logic [PW:0] wptr_q, rptr_q;
   logic [DW:0] fifo_mem_q [OST_DEPTH];
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;

   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[PW-1:0] == rptr_q[PW-1:0]) && (wptr_q[PW] != rptr_q[PW]);

   assign push = arr_vld & ~(fifo_empty & icb_resp_ready);
   assign pop  = ~fifo_empty & icb_resp_ready;

   always_comb begin
      if (fifo_empty) begin
         icb_resp_valid = arr_vld;
         icb_resp_rdata = arr_data;
         icb_resp_err   = arr_err;
      end else begin
         icb_resp_valid = 1'b1;
         {icb_resp_err, icb_resp_rdata} = fifo_mem_q[rptr_q[PW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + ONE;
         end
         if (pop) begin
            rptr_q <= rptr_q + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wptr_q[PW-1:0]] <= {arr_err, arr_data};
      end
   end

`ifndef SYNTHESIS
   fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && fifo_full && !pop));
`endif

endmodule

// File: tb/tb_srv_icb_mem_pipe.sv
// Directed bench for srv_icb_mem_pipe: instance A (RD_LAT=1) and instance B (RD_LAT=2),
// each with a behavioural SRAM of matching latency.
module tb_srv_icb_mem_pipe;

   logic clk;
   logic reset_n;
   logic model_init;
   int   nchk;
   int   nerr;

   // Instance A signals
   logic        a_cmd_valid, a_cmd_ready, a_cmd_read;
   logic [31:0] a_cmd_addr, a_cmd_wdata;
   logic [3:0]  a_cmd_wmask;
   logic        a_resp_valid, a_resp_ready, a_resp_err;
   logic [31:0] a_resp_rdata;
   logic        a_mem_ce, a_mem_we;
   logic [9:0]  a_mem_addr;
   logic [31:0] a_mem_bwe, a_mem_din, a_mem_dout;

   // Instance B signals
   logic        b_cmd_valid, b_cmd_ready, b_cmd_read;
   logic [31:0] b_cmd_addr, b_cmd_wdata;
   logic [3:0]  b_cmd_wmask;
   logic        b_resp_valid, b_resp_ready, b_resp_err;
   logic [31:0] b_resp_rdata;
   logic        b_mem_ce, b_mem_we;
   logic [9:0]  b_mem_addr;
   logic [31:0] b_mem_bwe, b_mem_din, b_mem_dout;

   srv_icb_mem_pipe #(
      .AW_ICB(32), .AW_MEM(10), .DW(32), .RD_LAT(1), .OST_DEPTH(2)
   ) u_dut_a (
      .clk(clk), .reset_n(reset_n),
      .icb_cmd_valid(a_cmd_valid), .icb_cmd_ready(a_cmd_ready), .icb_cmd_addr(a_cmd_addr),
      .icb_cmd_read(a_cmd_read), .icb_cmd_wdata(a_cmd_wdata), .icb_cmd_wmask(a_cmd_wmask),
      .icb_resp_valid(a_resp_valid), .icb_resp_ready(a_resp_ready),
      .icb_resp_rdata(a_resp_rdata), .icb_resp_err(a_resp_err),
      .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_bwe(a_mem_bwe),
      .mem_din(a_mem_din), .mem_dout(a_mem_dout)
   );

   srv_icb_mem_pipe #(
      .AW_ICB(32), .AW_MEM(10), .DW(32), .RD_LAT(2), .OST_DEPTH(2)
   ) u_dut_b (
      .clk(clk), .reset_n(reset_n),
      .icb_cmd_valid(b_cmd_valid), .icb_cmd_ready(b_cmd_ready), .icb_cmd_addr(b_cmd_addr),
      .icb_cmd_read(b_cmd_read), .icb_cmd_wdata(b_cmd_wdata), .icb_cmd_wmask(b_cmd_wmask),
      .icb_resp_valid(b_resp_valid), .icb_resp_ready(b_resp_ready),
      .icb_resp_rdata(b_resp_rdata), .icb_resp_err(b_resp_err),
      .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_bwe(b_mem_bwe),
      .mem_din(b_mem_din), .mem_dout(b_mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_a(input int unsigned w);
      logic [7:0] w8;
      w8 = w[7:0];
      if (w == 4) return 32'hDEADBEEF;
      return {8'h11 + w8, 8'h11 + w8, 8'h00, w8};
   endfunction

   function automatic logic [31:0] init_b(input logic [9:0] w);
      return 32'hCAFE_0000 | {22'h0, w};
   endfunction

   // SRAM model A: one-cycle read latency, bit-masked writes
   logic [31:0] mem_a [1024];
   logic [31:0] a_rd_q;
   always @(posedge clk) begin
      if (model_init) begin
         for (int i = 0; i < 1024; i++) mem_a[i] <= init_a(i);
      end else if (a_mem_ce) begin
         if (a_mem_we) begin
            mem_a[a_mem_addr] <= (mem_a[a_mem_addr] & ~a_mem_bwe) | (a_mem_din & a_mem_bwe);
         end else begin
            a_rd_q <= mem_a[a_mem_addr];
         end
      end
   end
   assign a_mem_dout = a_rd_q;

   // SRAM model B: read-only, two-cycle read latency
   logic [31:0] b_rd1_q, b_rd2_q;
   always @(posedge clk) begin
      if (b_mem_ce && !b_mem_we) b_rd1_q <= init_b(b_mem_addr);
      b_rd2_q <= b_rd1_q;
   end
   assign b_mem_dout = b_rd2_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] wm);
      a_cmd_valid = v;
      a_cmd_read  = rd;
      a_cmd_addr  = addr;
      a_cmd_wdata = wd;
      a_cmd_wmask = wm;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b0) begin nerr++;
         $display("FAIL reset_resp_valid: got %0b want 0", a_resp_valid); end
      nchk++; if (a_resp_err !== 1'b0) begin nerr++;
         $display("FAIL reset_resp_err: got %0b want 0", a_resp_err); end
      nchk++; if (a_resp_rdata !== 32'h0) begin nerr++;
         $display("FAIL reset_resp_rdata: got %h want 00000000", a_resp_rdata); end
      nchk++; if (a_cmd_ready !== 1'b1) begin nerr++;
         $display("FAIL reset_cmd_ready: got %0b want 1", a_cmd_ready); end
      nchk++; if (a_mem_ce !== 1'b0) begin nerr++;
         $display("FAIL reset_mem_ce: got %0b want 0", a_mem_ce); end
      nchk++; if (b_resp_valid !== 1'b0) begin nerr++;
         $display("FAIL reset_b_resp_valid: got %0b want 0", b_resp_valid); end
      tick();
      reset_n    = 1'b1;
      model_init = 1'b0;
   endtask

   task automatic test_single_read();
      tick();
      a_resp_ready = 1'b1;
      drive_a(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_mem_ce !== 1'b1) begin nerr++;
         $display("FAIL rd_mem_ce: got %0b want 1", a_mem_ce); end
      nchk++; if (a_mem_addr !== 10'd4) begin nerr++;
         $display("FAIL rd_mem_addr: got %0d want 4", a_mem_addr); end
      nchk++; if (a_resp_valid !== 1'b0) begin nerr++;
         $display("FAIL rd_early_valid: got %0b want 0", a_resp_valid); end
      tick();
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b1) begin nerr++;
         $display("FAIL rd_resp_valid: got %0b want 1", a_resp_valid); end
      nchk++; if (a_resp_rdata !== 32'hDEADBEEF) begin nerr++;
         $display("FAIL rd_resp_rdata: got %h want deadbeef", a_resp_rdata); end
      nchk++; if (a_resp_err !== 1'b0) begin nerr++;
         $display("FAIL rd_resp_err: got %0b want 0", a_resp_err); end
      tick();
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b0) begin nerr++;
         $display("FAIL rd_resp_retired: got %0b want 0", a_resp_valid); end
   endtask

   task automatic test_write();
      tick();
      drive_a(1'b1, 1'b0, 32'h8, 32'h12345678, 4'b0101);
      @(negedge clk);
      nchk++; if (a_mem_ce !== 1'b1 || a_mem_we !== 1'b1) begin nerr++;
         $display("FAIL wr_ce_we: got %0b%0b want 11", a_mem_ce, a_mem_we); end
      nchk++; if (a_mem_bwe !== 32'h00FF00FF) begin nerr++;
         $display("FAIL wr_mem_bwe: got %h want 00ff00ff", a_mem_bwe); end
      nchk++; if (a_mem_din !== 32'h12345678) begin nerr++;
         $display("FAIL wr_mem_din: got %h want 12345678", a_mem_din); end
      nchk++; if (a_mem_addr !== 10'd2) begin nerr++;
         $display("FAIL wr_mem_addr: got %0d want 2", a_mem_addr); end
      tick();
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0)
         begin nerr++;
         $display("FAIL wr_resp: got v=%0b d=%h e=%0b want v=1 d=00000000 e=0",
                  a_resp_valid, a_resp_rdata, a_resp_err); end
      tick();
      drive_a(1'b1, 1'b1, 32'h8, 32'h0, 4'h0);
      tick();
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h13340078) begin nerr++;
         $display("FAIL wr_readback: got v=%0b d=%h want v=1 d=13340078",
                  a_resp_valid, a_resp_rdata); end
   endtask

   task automatic test_backpressure();
      tick();
      a_resp_ready = 1'b0;
      drive_a(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_cmd_ready !== 1'b1) begin nerr++;
         $display("FAIL bp_ready_first: got %0b want 1", a_cmd_ready); end
      tick();
      drive_a(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_cmd_ready !== 1'b1) begin nerr++;
         $display("FAIL bp_ready_second: got %0b want 1", a_cmd_ready); end
      nchk++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h11110000) begin nerr++;
         $display("FAIL bp_first_arrival: got v=%0b d=%h want v=1 d=11110000",
                  a_resp_valid, a_resp_rdata); end
      tick();
      drive_a(1'b1, 1'b1, 32'h8, 32'h0, 4'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         nchk++; if (a_cmd_ready !== 1'b0) begin nerr++;
            $display("FAIL bp_full_ready[%0d]: got %0b want 0", k, a_cmd_ready); end
         nchk++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h11110000) begin nerr++;
            $display("FAIL bp_hold[%0d]: got v=%0b d=%h want v=1 d=11110000",
                     k, a_resp_valid, a_resp_rdata); end
         if (k < 2) tick();
      end
      tick();
      a_resp_ready = 1'b1;
      @(negedge clk);
      nchk++; if (a_cmd_ready !== 1'b1) begin nerr++;
         $display("FAIL bp_ready_on_retire: got %0b want 1", a_cmd_ready); end
      nchk++; if (a_resp_rdata !== 32'h11110000) begin nerr++;
         $display("FAIL bp_resp0: got %h want 11110000", a_resp_rdata); end
      tick();
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h12120001) begin nerr++;
         $display("FAIL bp_resp1: got v=%0b d=%h want v=1 d=12120001",
                  a_resp_valid, a_resp_rdata); end
      tick();
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h13340078) begin nerr++;
         $display("FAIL bp_resp2: got v=%0b d=%h want v=1 d=13340078",
                  a_resp_valid, a_resp_rdata); end
      tick();
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b0) begin nerr++;
         $display("FAIL bp_drained: got %0b want 0", a_resp_valid); end
   endtask

   task automatic test_back_to_back();
      logic        exp_v;
      logic [31:0] exp_d;
      b_resp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         b_cmd_valid = (c < 3);
         b_cmd_read  = 1'b1;
         b_cmd_addr  = 32'(c * 4);
         @(negedge clk);
         if (c < 3) begin
            nchk++; if (b_cmd_ready !== 1'b1) begin nerr++;
               $display("FAIL b2b_cmd_ready[%0d]: got %0b want 1", c, b_cmd_ready); end
         end
         exp_v = (c >= 2 && c <= 4);
         nchk++; if (b_resp_valid !== exp_v) begin nerr++;
            $display("FAIL b2b_valid[%0d]: got %0b want %0b", c, b_resp_valid, exp_v); end
         if (exp_v) begin
            exp_d = 32'hCAFE_0000 | 32'(c - 2);
            nchk++; if (b_resp_rdata !== exp_d) begin nerr++;
               $display("FAIL b2b_rdata[%0d]: got %h want %h", c, b_resp_rdata, exp_d); end
         end
      end
   endtask

   task automatic test_addr_err();
      tick();
      a_resp_ready = 1'b1;
      drive_a(1'b1, 1'b1, 32'h0000_1000, 32'h0, 4'h0);
      @(negedge clk);
`ifdef SRV_ICB_MEM_ADDR_CHK_EN
      nchk++; if (a_mem_ce !== 1'b0) begin nerr++;
         $display("FAIL aerr_mem_ce: got %0b want 0", a_mem_ce); end
`else
      nchk++; if (a_mem_ce !== 1'b1 || a_mem_addr !== 10'd0) begin nerr++;
         $display("FAIL alias_mem: got ce=%0b addr=%0d want ce=1 addr=0", a_mem_ce, a_mem_addr);
      end
`endif
      tick();
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
`ifdef SRV_ICB_MEM_ADDR_CHK_EN
      nchk++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b1 || a_resp_rdata !== 32'h0)
         begin nerr++;
         $display("FAIL aerr_resp: got v=%0b e=%0b d=%h want v=1 e=1 d=00000000",
                  a_resp_valid, a_resp_err, a_resp_rdata); end
`else
      nchk++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b0 || a_resp_rdata !== 32'h11110000)
         begin nerr++;
         $display("FAIL alias_resp: got v=%0b e=%0b d=%h want v=1 e=0 d=11110000",
                  a_resp_valid, a_resp_err, a_resp_rdata); end
`endif
   endtask

   task automatic test_reset_midway();
      tick();
      a_resp_ready = 1'b0;
      drive_a(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
      tick();
      drive_a(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
      tick();
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b1 || a_cmd_ready !== 1'b0) begin nerr++;
         $display("FAIL mid_buffered: got v=%0b rdy=%0b want v=1 rdy=0",
                  a_resp_valid, a_cmd_ready); end
      tick();
      #1;
      reset_n = 1'b0;
      #1;
      nchk++; if (a_resp_valid !== 1'b0) begin nerr++;
         $display("FAIL mid_rst_valid: got %0b want 0", a_resp_valid); end
      nchk++; if (a_cmd_ready !== 1'b1) begin nerr++;
         $display("FAIL mid_rst_ready: got %0b want 1", a_cmd_ready); end
      nchk++; if (a_resp_rdata !== 32'h0 || a_resp_err !== 1'b0) begin nerr++;
         $display("FAIL mid_rst_data: got d=%h e=%0b want d=00000000 e=0",
                  a_resp_rdata, a_resp_err); end
      tick();
      reset_n      = 1'b1;
      a_resp_ready = 1'b1;
      tick();
      drive_a(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b0 || a_mem_ce !== 1'b1) begin nerr++;
         $display("FAIL post_rst_issue: got v=%0b ce=%0b want v=0 ce=1", a_resp_valid, a_mem_ce);
      end
      tick();
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'hDEADBEEF) begin nerr++;
         $display("FAIL post_rst_resp: got v=%0b d=%h want v=1 d=deadbeef",
                  a_resp_valid, a_resp_rdata); end
      tick();
      @(negedge clk);
      nchk++; if (a_resp_valid !== 1'b0) begin nerr++;
         $display("FAIL post_rst_no_replay: got %0b want 0", a_resp_valid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nchk         = 0;
      nerr         = 0;
      reset_n      = 1'b0;
      model_init   = 1'b1;
      a_resp_ready = 1'b0;
      b_resp_ready = 1'b0;
      drive_a(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
      b_cmd_valid  = 1'b0;
      b_cmd_read   = 1'b1;
      b_cmd_addr   = 32'h0;
      b_cmd_wdata  = 32'h0;
      b_cmd_wmask  = 4'h0;
      test_reset();
      test_single_read();
      test_write();
      test_backpressure();
      test_back_to_back();
      test_addr_err();
      test_reset_midway();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

endmodule
